// File: rtl/mem_stage_pkg.sv
// Shared encodings for the memory stage: result-source select, load/store
// funct3 sizes and the memory-handshake state type.
package mem_stage_pkg;

    localparam logic [1:0] RES_ALU  = 2'b00;
    localparam logic [1:0] RES_LOAD = 2'b01;
    localparam logic [1:0] RES_PC4  = 2'b10;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {
        ST_IDLE,
        ST_WAIT
    } state_t;

endpackage

// File: rtl/mem_stage_load_extend.sv
// Load lane selection and sign/zero extension of the returned read word.
module load_extend
    import mem_stage_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    output logic [31:0] data
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        byte_lane = rdata[7:0];
        case (offset)
            2'd1:    byte_lane = rdata[15:8];
            2'd2:    byte_lane = rdata[23:16];
            2'd3:    byte_lane = rdata[31:24];
            default: byte_lane = rdata[7:0];
        endcase
        half_lane = offset[1] ? rdata[31:16] : rdata[15:0];

        case (funct3)
            F3_B:    data = {{24{byte_lane[7]}}, byte_lane};
            F3_H:    data = {{16{half_lane[15]}}, half_lane};
            F3_BU:   data = {24'b0, byte_lane};
            F3_HU:   data = {16'b0, half_lane};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Pipeline memory stage: data-memory handshake, store lane alignment, load
// extension and the MEM/WB register. Optional trap: `MISALIGN_TRAP_EN.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        regwrite_m,
    input  logic [1:0]  result_src_m,
    input  logic        memwrite_m,
    input  logic [2:0]  funct3_m,
    input  logic [31:0] alu_result_m,
    input  logic [31:0] writedata_m,
    input  logic [4:0]  rd_m,
    input  logic [31:0] pc_plus_4_m,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        stall_m,
    output logic        regwrite_w,
    output logic [1:0]  result_src_w,
    output logic [4:0]  rd_w,
    output logic [31:0] alu_result_w,
    output logic [31:0] read_data_w,
    output logic [31:0] pc_plus_4_w,
    output logic        misalign_m
);

    state_t      state, state_next;
    logic        access;
    logic        is_load;
    logic        trap;
    logic [31:0] load_data;

    assign is_load = (result_src_m == RES_LOAD);
    assign access  = memwrite_m | is_load;

`ifdef MISALIGN_TRAP_EN
    logic misaligned;
    always_comb begin
        case (funct3_m)
            F3_H, F3_HU: misaligned = alu_result_m[0];
            F3_W:        misaligned = (alu_result_m[1:0] != 2'b00);
            default:     misaligned = 1'b0;
        endcase
    end
    assign trap = access & misaligned;
`else
    assign trap = 1'b0;
`endif

    assign misalign_m = trap;
    assign dmem_req   = access & ~trap & ~reset;
    assign dmem_we    = dmem_req & memwrite_m;
    assign dmem_addr  = {alu_result_m[31:2], 2'b00};
    assign stall_m    = dmem_req & ~dmem_ack;

    always_comb begin
        dmem_be    = 4'hF;
        dmem_wdata = writedata_m;
        if (memwrite_m) begin
            case (funct3_m)
                F3_B: begin
                    dmem_be    = 4'b0001 << alu_result_m[1:0];
                    dmem_wdata = {4{writedata_m[7:0]}};
                end
                F3_H: begin
                    dmem_be    = 4'b0011 << {alu_result_m[1], 1'b0};
                    dmem_wdata = {2{writedata_m[15:0]}};
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    // An ack seen in IDLE with no request falls through unchanged.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (dmem_req && !dmem_ack) state_next = ST_WAIT;
            ST_WAIT: if (dmem_ack)              state_next = ST_IDLE;
            default:                            state_next = ST_IDLE;
        endcase
    end

    load_extend u_load_extend (
        .rdata  (dmem_rdata),
        .funct3 (funct3_m),
        .offset (alu_result_m[1:0]),
        .data   (load_data)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            regwrite_w   <= 1'b0;
            result_src_w <= '0;
            rd_w         <= '0;
            alu_result_w <= '0;
            read_data_w  <= '0;
            pc_plus_4_w  <= '0;
        end else if (stall_m) begin
            regwrite_w <= 1'b0;
        end else begin
            regwrite_w   <= regwrite_m & ~trap;
            result_src_w <= result_src_m;
            rd_w         <= rd_m;
            alu_result_w <= alu_result_m;
            read_data_w  <= (is_load && !trap) ? load_data : '0;
            pc_plus_4_w  <= pc_plus_4_m;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage (honours `MISALIGN_TRAP_EN).
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        regwrite_m;
    logic [1:0]  result_src_m;
    logic        memwrite_m;
    logic [2:0]  funct3_m;
    logic [31:0] alu_result_m, writedata_m, pc_plus_4_m;
    logic [4:0]  rd_m;
    logic        dmem_req, dmem_we, dmem_ack, stall_m, misalign_m;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_be;
    logic        regwrite_w;
    logic [1:0]  result_src_w;
    logic [4:0]  rd_w;
    logic [31:0] alu_result_w, read_data_w, pc_plus_4_w;

    int checks = 0;
    int errors = 0;

    mem_stage dut (
        .clk(clk), .reset(reset),
        .regwrite_m(regwrite_m), .result_src_m(result_src_m),
        .memwrite_m(memwrite_m), .funct3_m(funct3_m),
        .alu_result_m(alu_result_m), .writedata_m(writedata_m),
        .rd_m(rd_m), .pc_plus_4_m(pc_plus_4_m),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .stall_m(stall_m),
        .regwrite_w(regwrite_w), .result_src_w(result_src_w), .rd_w(rd_w),
        .alu_result_w(alu_result_w), .read_data_w(read_data_w),
        .pc_plus_4_w(pc_plus_4_w), .misalign_m(misalign_m)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic nop();
        regwrite_m = 0; result_src_m = RES_ALU; memwrite_m = 0; funct3_m = 0;
        alu_result_m = 0; writedata_m = 0; rd_m = 0; pc_plus_4_m = 0;
        dmem_ack = 0; dmem_rdata = 0;
    endtask

    task automatic load(input logic [2:0] f3, input logic [31:0] a, input logic [4:0] rd);
        nop();
        regwrite_m = 1; result_src_m = RES_LOAD; funct3_m = f3; alu_result_m = a; rd_m = rd;
    endtask

    task automatic store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        nop();
        memwrite_m = 1; funct3_m = f3; alu_result_m = a; writedata_m = d; rd_m = 5'd7;
    endtask

    initial begin
        // Reset with a load request on the inputs: request must stay gated.
        reset = 1;
        load(F3_W, 32'h200, 5'd3);
        #1;
        chk("rst_req", 32'(dmem_req), 0);
        chk("rst_stall", 32'(stall_m), 0);
        @(posedge clk); #1;
        chk("rst_regwrite_w", 32'(regwrite_w), 0);
        chk("rst_alu_w", alu_result_w, 0);
        chk("rst_rd_w", 32'(rd_w), 0);
        chk("rst_state", 32'(dut.state), 32'(ST_IDLE));

        @(negedge clk); reset = 0; nop();

        // ALU op
        @(negedge clk);
        regwrite_m = 1; rd_m = 5'd5; alu_result_m = 32'h1234; pc_plus_4_m = 32'h40;
        #1;
        chk("alu_req", 32'(dmem_req), 0);
        chk("alu_stall", 32'(stall_m), 0);
        @(posedge clk); #1;
        chk("alu_regwrite_w", 32'(regwrite_w), 1);
        chk("alu_rd_w", 32'(rd_w), 5);
        chk("alu_alu_w", alu_result_w, 32'h1234);
        chk("alu_rdata_w", read_data_w, 0);
        chk("alu_pc4_w", pc_plus_4_w, 32'h40);
        chk("alu_src_w", 32'(result_src_w), 32'(RES_ALU));

        // SW with three wait cycles
        @(negedge clk);
        store(F3_W, 32'h100, 32'hDEADBEEF);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("sw_stall", 32'(stall_m), 1);
            chk("sw_req", 32'(dmem_req), 1);
            chk("sw_we", 32'(dmem_we), 1);
            chk("sw_be", 32'(dmem_be), 32'hF);
            chk("sw_wdata", dmem_wdata, 32'hDEADBEEF);
            chk("sw_addr", dmem_addr, 32'h100);
            @(posedge clk); #1;
            chk("sw_bubble", 32'(regwrite_w), 0);
            chk("sw_hold_rd", 32'(rd_w), 5);
            chk("sw_hold_alu", alu_result_w, 32'h1234);
            chk("sw_state", 32'(dut.state), 32'(ST_WAIT));
            @(negedge clk);
        end
        dmem_ack = 1;
        #1;
        chk("sw_ack_stall", 32'(stall_m), 0);
        @(posedge clk); #1;
        chk("sw_done_alu", alu_result_w, 32'h100);
        chk("sw_done_rd", 32'(rd_w), 7);
        chk("sw_done_state", 32'(dut.state), 32'(ST_IDLE));

        // SB zero-wait at byte 3
        @(negedge clk);
        store(F3_B, 32'h103, 32'h000000A5);
        dmem_ack = 1;
        #1;
        chk("sb_be", 32'(dmem_be), 32'b1000);
        chk("sb_wdata", dmem_wdata, 32'hA5A5A5A5);
        chk("sb_addr", dmem_addr, 32'h100);
        chk("sb_stall", 32'(stall_m), 0);
        @(posedge clk); #1;
        chk("sb_state", 32'(dut.state), 32'(ST_IDLE));
        chk("sb_alu_w", alu_result_w, 32'h103);

        // SH upper half
        @(negedge clk);
        store(F3_H, 32'h102, 32'h1234BEEF);
        dmem_ack = 1;
        #1;
        chk("sh_be", 32'(dmem_be), 32'b1100);
        chk("sh_wdata", dmem_wdata, 32'hBEEFBEEF);

        // Byte/half loads, zero-wait
        @(negedge clk);
        load(F3_B, 32'h102, 5'd9); dmem_ack = 1; dmem_rdata = 32'h00800000;
        #1;
        chk("lb_we", 32'(dmem_we), 0);
        chk("lb_be", 32'(dmem_be), 32'hF);
        chk("lb_stall", 32'(stall_m), 0);
        @(posedge clk); #1;
        chk("lb_data", read_data_w, 32'hFFFFFF80);
        chk("lb_regwrite_w", 32'(regwrite_w), 1);
        chk("lb_rd_w", 32'(rd_w), 9);
        chk("lb_src_w", 32'(result_src_w), 32'(RES_LOAD));
        @(negedge clk);
        load(F3_BU, 32'h102, 5'd9); dmem_ack = 1; dmem_rdata = 32'h00800000;
        @(posedge clk); #1;
        chk("lbu_data", read_data_w, 32'h00000080);
        @(negedge clk);
        load(F3_H, 32'h102, 5'd10); dmem_ack = 1; dmem_rdata = 32'h80010000;
        @(posedge clk); #1;
        chk("lh_data", read_data_w, 32'hFFFF8001);
        @(negedge clk);
        load(F3_HU, 32'h102, 5'd10); dmem_ack = 1; dmem_rdata = 32'h80010000;
        @(posedge clk); #1;
        chk("lhu_data", read_data_w, 32'h00008001);

        // LW with one wait cycle
        @(negedge clk);
        load(F3_W, 32'h104, 5'd11);
        #1;
        chk("lw_stall", 32'(stall_m), 1);
        @(posedge clk); #1;
        chk("lw_bubble", 32'(regwrite_w), 0);
        @(negedge clk);
        dmem_ack = 1; dmem_rdata = 32'hCAFEF00D;
        @(posedge clk); #1;
        chk("lw_data", read_data_w, 32'hCAFEF00D);
        chk("lw_regwrite_w", 32'(regwrite_w), 1);
        chk("lw_rd_w", 32'(rd_w), 11);

        // Stray ack with no request
        @(negedge clk);
        nop(); dmem_ack = 1;
        #1;
        chk("stray_stall", 32'(stall_m), 0);
        @(posedge clk); #1;
        chk("stray_state", 32'(dut.state), 32'(ST_IDLE));
        chk("stray_rdata_w", read_data_w, 0);

        // Reset asserted during WAIT, ack arrives one cycle later
        @(negedge clk);
        load(F3_W, 32'h300, 5'd12);
        @(posedge clk); #1;
        chk("rw_state_wait", 32'(dut.state), 32'(ST_WAIT));
        reset = 1;
        #1;
        chk("rw_req", 32'(dmem_req), 0);
        chk("rw_stall", 32'(stall_m), 0);
        chk("rw_state", 32'(dut.state), 32'(ST_IDLE));
        chk("rw_regwrite_w", 32'(regwrite_w), 0);
        chk("rw_rd_w", 32'(rd_w), 0);
        @(negedge clk);
        reset = 0; nop(); dmem_ack = 1;
        @(posedge clk); #1;
        chk("rw_after_state", 32'(dut.state), 32'(ST_IDLE));
        chk("rw_after_regwrite_w", 32'(regwrite_w), 0);

        // Misaligned LW
        @(negedge clk);
        load(F3_W, 32'h101, 5'd13);
`ifdef MISALIGN_TRAP_EN
        #1;
        chk("mis_flag", 32'(misalign_m), 1);
        chk("mis_req", 32'(dmem_req), 0);
        chk("mis_stall", 32'(stall_m), 0);
        @(posedge clk); #1;
        chk("mis_regwrite_w", 32'(regwrite_w), 0);
`else
        dmem_ack = 1; dmem_rdata = 32'h11223344;
        #1;
        chk("mis_flag", 32'(misalign_m), 0);
        chk("mis_req", 32'(dmem_req), 1);
        chk("mis_addr", dmem_addr, 32'h100);
        @(posedge clk); #1;
        chk("mis_data", read_data_w, 32'h11223344);
        chk("mis_regwrite_w", 32'(regwrite_w), 1);
`endif

        @(negedge clk); nop();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
